// File: rtl/memory_pkg.sv
// Shared types for the L2-TLB miss-handling path: VPN, requester tag and MSHR entry state.
package memory_pkg;

  localparam int L2_TLB_MSHR_ENTRIES      = 4;
  localparam int L2_TLB_MSHR_MAX_INFLIGHT = 2;
  localparam int VPN_W                    = 27;

  typedef logic [VPN_W-1:0] vpn_t;

  typedef enum logic {
    ITLB = 1'b0,
    DTLB = 1'b1
  } tlb_arb_tag_e;

  typedef enum logic [1:0] {
    FREE,
    PENDING,
    INFLIGHT,
    ZOMBIE
  } l2tlb_mshr_state_e;

  typedef logic [$clog2(L2_TLB_MSHR_ENTRIES)-1:0] l2tlb_mshr_id_t;

  function automatic logic [1:0] dest_onehot(input tlb_arb_tag_e dest);
    return (dest == DTLB) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/l2_tlb_mshr_id_fifo.sv
// Circular FIFO of MSHR entry IDs in allocation order; a count register keeps full/empty exact across wrap.
module l2_tlb_mshr_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 2
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clear_i,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         empty_o,
  output logic         full_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/l2_tlb_mshr_ooo.sv
// Multi-entry MSHR between L2-TLB misses and the PTW; walks issue in order, answers return by ID.
// Optional same-VPN request merging is enabled by defining L2_TLB_MSHR_MERGE_EN.
module l2_tlb_mshr_ooo
  import memory_pkg::*;
#(
  parameter  int N            = L2_TLB_MSHR_ENTRIES,
  parameter  int MAX_INFLIGHT = L2_TLB_MSHR_MAX_INFLIGHT,
  localparam int IDW          = $clog2(N)
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           flush_i,
  input  logic           req_valid_i,
  output logic           req_ready_o,
  input  vpn_t           req_vpn_i,
  input  tlb_arb_tag_e   req_dest_i,
  output logic           ptw_req_valid_o,
  input  logic           ptw_req_ready_i,
  output vpn_t           ptw_req_vpn_o,
  output logic [IDW-1:0] ptw_req_id_o,
  input  logic           ptw_ans_valid_i,
  input  logic [IDW-1:0] ptw_ans_id_i,
  output logic           ans_valid_o,
  output vpn_t           ans_vpn_o,
  output logic [1:0]     ans_dest_mask_o,
  output logic           full_o,
  output logic           empty_o
);

  localparam int CNTW = $clog2(N + 1);

  l2tlb_mshr_state_e state_q [N];
  l2tlb_mshr_state_e state_d [N];
  vpn_t              vpn_q   [N];
  vpn_t              vpn_d   [N];
  logic [1:0]        mask_q  [N];
  logic [1:0]        mask_d  [N];
  logic [CNTW-1:0]   inflight_cnt_q, inflight_cnt_d;
  logic              ans_valid_q, ans_valid_d;
  vpn_t              ans_vpn_q, ans_vpn_d;
  logic [1:0]        ans_mask_q, ans_mask_d;

  logic              full, empty;
  logic [IDW-1:0]    alloc_idx;
  logic              merge_hit;
  logic [IDW-1:0]    merge_idx;
  logic              req_fire, alloc_do, merge_do, issue_hs;
  logic              ans_live, ans_retire;
  l2tlb_mshr_state_e ans_state;
  logic [IDW-1:0]    q_head;
  logic              q_empty, q_full;

  always_comb begin
    full      = 1'b1;
    empty     = 1'b1;
    alloc_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (state_q[i] == FREE) begin
        full      = 1'b0;
        alloc_idx = IDW'(i);
      end else begin
        empty = 1'b0;
      end
    end
  end

`ifdef L2_TLB_MSHR_MERGE_EN
  // An entry answered this cycle is about to retire, so it must not absorb a new requester.
  always_comb begin
    merge_hit = 1'b0;
    merge_idx = '0;
    for (int i = 0; i < N; i++) begin
      if ((state_q[i] == PENDING || state_q[i] == INFLIGHT) && vpn_q[i] == req_vpn_i &&
          !(ptw_ans_valid_i && ptw_ans_id_i == IDW'(i))) begin
        merge_hit = 1'b1;
        merge_idx = IDW'(i);
      end
    end
  end
`else
  assign merge_hit = 1'b0;
  assign merge_idx = '0;
`endif

  assign full_o          = full;
  assign empty_o         = empty;
  assign req_ready_o     = !flush_i && (!full || merge_hit);
  assign req_fire        = req_valid_i && req_ready_o;
  assign alloc_do        = req_fire && !merge_hit;
  assign merge_do        = req_fire && merge_hit;
  assign ptw_req_valid_o = !flush_i && !q_empty && (inflight_cnt_q < CNTW'(MAX_INFLIGHT));
  assign ptw_req_id_o    = q_head;
  assign ptw_req_vpn_o   = vpn_q[q_head];
  assign issue_hs        = ptw_req_valid_o && ptw_req_ready_i;
  assign ans_state       = state_q[ptw_ans_id_i];
  assign ans_retire      = ptw_ans_valid_i && (ans_state == INFLIGHT || ans_state == ZOMBIE);
  assign ans_live        = ptw_ans_valid_i && (ans_state == INFLIGHT) && !flush_i;

  assign ans_valid_o     = ans_valid_q;
  assign ans_vpn_o       = ans_vpn_q;
  assign ans_dest_mask_o = ans_mask_q;

  l2_tlb_mshr_id_fifo #(
    .DEPTH (N),
    .W     (IDW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .clear_i (flush_i),
    .push_i  (alloc_do),
    .data_i  (alloc_idx),
    .pop_i   (issue_hs),
    .head_o  (q_head),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  // Retirement is applied last so an answer coinciding with a flush frees the entry instead of leaving a zombie.
  always_comb begin
    state_d = state_q;
    vpn_d   = vpn_q;
    mask_d  = mask_q;
    if (flush_i) begin
      for (int i = 0; i < N; i++) begin
        if (state_q[i] == PENDING)  state_d[i] = FREE;
        if (state_q[i] == INFLIGHT) state_d[i] = ZOMBIE;
      end
    end
    if (alloc_do) begin
      state_d[alloc_idx] = PENDING;
      vpn_d[alloc_idx]   = req_vpn_i;
      mask_d[alloc_idx]  = dest_onehot(req_dest_i);
    end
    if (merge_do) mask_d[merge_idx] = mask_q[merge_idx] | dest_onehot(req_dest_i);
    if (issue_hs) state_d[q_head] = INFLIGHT;
    if (ans_retire) state_d[ptw_ans_id_i] = FREE;

    inflight_cnt_d = inflight_cnt_q + CNTW'(issue_hs) - CNTW'(ans_retire);
    ans_valid_d    = ans_live;
    ans_vpn_d      = ans_live ? vpn_q[ptw_ans_id_i] : '0;
    ans_mask_d     = ans_live ? mask_q[ptw_ans_id_i] : 2'b00;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < N; i++) begin
        state_q[i] <= FREE;
        vpn_q[i]   <= '0;
        mask_q[i]  <= '0;
      end
      inflight_cnt_q <= '0;
      ans_valid_q    <= 1'b0;
      ans_vpn_q      <= '0;
      ans_mask_q     <= '0;
    end else begin
      state_q        <= state_d;
      vpn_q          <= vpn_d;
      mask_q         <= mask_d;
      inflight_cnt_q <= inflight_cnt_d;
      ans_valid_q    <= ans_valid_d;
      ans_vpn_q      <= ans_vpn_d;
      ans_mask_q     <= ans_mask_d;
    end
  end

  a_ans_on_walk: assert property (@(posedge clk_i) disable iff (!rst_ni)
    ptw_ans_valid_i |-> (ans_state == INFLIGHT || ans_state == ZOMBIE));

  a_queue_no_overflow: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(alloc_do && q_full));

  a_inflight_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    inflight_cnt_q <= CNTW'(MAX_INFLIGHT));

endmodule

// File: tb/tb_l2_tlb_mshr_ooo.sv
// Directed bench for l2_tlb_mshr_ooo (N=4, MAX_INFLIGHT=2); merge expectations follow L2_TLB_MSHR_MERGE_EN.
module tb_l2_tlb_mshr_ooo;
  import memory_pkg::*;

  localparam int IDW = 2;
  localparam int MAXI = 2;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic           flush_i = 1'b0;
  logic           req_valid_i = 1'b0;
  logic           req_ready_o;
  vpn_t           req_vpn_i = '0;
  tlb_arb_tag_e   req_dest_i = ITLB;
  logic           ptw_req_valid_o;
  logic           ptw_req_ready_i = 1'b0;
  vpn_t           ptw_req_vpn_o;
  logic [IDW-1:0] ptw_req_id_o;
  logic           ptw_ans_valid_i = 1'b0;
  logic [IDW-1:0] ptw_ans_id_i = '0;
  logic           ans_valid_o;
  vpn_t           ans_vpn_o;
  logic [1:0]     ans_dest_mask_o;
  logic           full_o;
  logic           empty_o;

  int n_cmp = 0;
  int n_mis = 0;

  l2_tlb_mshr_ooo dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .flush_i         (flush_i),
    .req_valid_i     (req_valid_i),
    .req_ready_o     (req_ready_o),
    .req_vpn_i       (req_vpn_i),
    .req_dest_i      (req_dest_i),
    .ptw_req_valid_o (ptw_req_valid_o),
    .ptw_req_ready_i (ptw_req_ready_i),
    .ptw_req_vpn_o   (ptw_req_vpn_o),
    .ptw_req_id_o    (ptw_req_id_o),
    .ptw_ans_valid_i (ptw_ans_valid_i),
    .ptw_ans_id_i    (ptw_ans_id_i),
    .ans_valid_o     (ans_valid_o),
    .ans_vpn_o       (ans_vpn_o),
    .ans_dest_mask_o (ans_dest_mask_o),
    .full_o          (full_o),
    .empty_o         (empty_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic idle_inputs();
    flush_i = 1'b0; req_valid_i = 1'b0; req_vpn_i = '0; req_dest_i = ITLB;
    ptw_req_ready_i = 1'b0; ptw_ans_valid_i = 1'b0; ptw_ans_id_i = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    n_cmp++; if (empty_o !== 1'b1) begin n_mis++; $display("[TB] FAIL reset_empty: got %b want 1", empty_o); end
    n_cmp++; if (full_o !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_full: got %b want 0", full_o); end
    n_cmp++; if (req_ready_o !== 1'b1) begin n_mis++; $display("[TB] FAIL reset_req_ready: got %b want 1", req_ready_o); end
    n_cmp++; if (ptw_req_valid_o !== 1'b0) begin n_mis++; $display("[TB] FAIL reset_ptw_valid: got %b want 0", ptw_req_valid_o); end
    n_cmp++; if (ans_valid_o !== 1'b0 || ans_dest_mask_o !== 2'b00 || ans_vpn_o !== '0) begin
      n_mis++; $display("[TB] FAIL reset_ans: got v=%b m=%b vpn=%h want 0/00/0", ans_valid_o, ans_dest_mask_o, ans_vpn_o); end
    req_valid_i = 1'b1; req_vpn_i = 27'h100; req_dest_i = ITLB;
    step();
    req_valid_i = 1'b0; #1;
    n_cmp++; if (ptw_req_valid_o !== 1'b1) begin n_mis++; $display("[TB] FAIL first_issue_valid: got %b want 1", ptw_req_valid_o); end
    n_cmp++; if (ptw_req_vpn_o !== 27'h100) begin n_mis++; $display("[TB] FAIL first_issue_vpn: got %h want 100", ptw_req_vpn_o); end
    n_cmp++; if (ptw_req_id_o !== 2'd0) begin n_mis++; $display("[TB] FAIL first_issue_id: got %0d want 0", ptw_req_id_o); end
  endtask

  // Four allocations with an always-ready PTW: only two walks may be outstanding.
  task automatic test_fill();
    int issued[$];
    do_reset();
    ptw_req_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_valid_i = 1'b1; req_vpn_i = 27'h100 + 27'(i); req_dest_i = ITLB;
      #1;
      n_cmp++; if (req_ready_o !== 1'b1) begin n_mis++; $display("[TB] FAIL fill_ready_%0d: got %b want 1", i, req_ready_o); end
      if (ptw_req_valid_o && ptw_req_ready_i) issued.push_back(int'(ptw_req_id_o));
      step();
    end
    for (int i = 0; i < 2; i++) begin
      req_valid_i = 1'b1; req_vpn_i = 27'h104;
      #1;
      n_cmp++; if (full_o !== 1'b1) begin n_mis++; $display("[TB] FAIL full_flag_%0d: got %b want 1", i, full_o); end
      n_cmp++; if (req_ready_o !== 1'b0) begin n_mis++; $display("[TB] FAIL full_req_ready_%0d: got %b want 0", i, req_ready_o); end
      n_cmp++; if (ptw_req_valid_o !== 1'b0) begin n_mis++; $display("[TB] FAIL max_inflight_hold_%0d: got %b want 0", i, ptw_req_valid_o); end
      if (ptw_req_valid_o && ptw_req_ready_i) issued.push_back(int'(ptw_req_id_o));
      step();
    end
    req_valid_i = 1'b0;
    n_cmp++; if (issued.size() !== 2) begin n_mis++; $display("[TB] FAIL fill_issue_count: got %0d want 2", issued.size()); end
    else begin
      n_cmp++; if (issued[0] !== 0 || issued[1] !== 1) begin n_mis++; $display("[TB] FAIL fill_issue_order: got %0d,%0d want 0,1", issued[0], issued[1]); end
    end
  endtask

  // Continues from test_fill: answers come back out of order and free slots for ids 2 and 3.
  task automatic test_ooo_answer();
    ptw_ans_valid_i = 1'b1; ptw_ans_id_i = 2'd1;
    #1;
    n_cmp++; if (ptw_req_valid_o !== 1'b0) begin n_mis++; $display("[TB] FAIL ooo_no_issue: got %b want 0", ptw_req_valid_o); end
    step();
    ptw_ans_valid_i = 1'b0; #1;
    n_cmp++; if (ans_valid_o !== 1'b1 || ans_vpn_o !== 27'h101 || ans_dest_mask_o !== 2'b01) begin
      n_mis++; $display("[TB] FAIL ans_id1: got v=%b vpn=%h m=%b want 1/101/01", ans_valid_o, ans_vpn_o, ans_dest_mask_o); end
    n_cmp++; if (full_o !== 1'b0 || req_ready_o !== 1'b1) begin n_mis++; $display("[TB] FAIL slot_freed: got full=%b ready=%b want 0/1", full_o, req_ready_o); end
    n_cmp++; if (ptw_req_valid_o !== 1'b1 || ptw_req_id_o !== 2'd2) begin n_mis++; $display("[TB] FAIL issue_id2: got v=%b id=%0d want 1/2", ptw_req_valid_o, ptw_req_id_o); end
    step();
    ptw_ans_valid_i = 1'b1; ptw_ans_id_i = 2'd0;
    #1;
    n_cmp++; if (ans_valid_o !== 1'b0) begin n_mis++; $display("[TB] FAIL ans_one_cycle: got %b want 0", ans_valid_o); end
    step();
    ptw_ans_valid_i = 1'b0; #1;
    n_cmp++; if (ans_valid_o !== 1'b1 || ans_vpn_o !== 27'h100) begin n_mis++; $display("[TB] FAIL ans_id0: got v=%b vpn=%h want 1/100", ans_valid_o, ans_vpn_o); end
    n_cmp++; if (ptw_req_valid_o !== 1'b1 || ptw_req_id_o !== 2'd3) begin n_mis++; $display("[TB] FAIL issue_id3: got v=%b id=%0d want 1/3", ptw_req_valid_o, ptw_req_id_o); end
    step();
    ptw_ans_valid_i = 1'b1; ptw_ans_id_i = 2'd2;
    step();
    ptw_ans_id_i = 2'd3; #1;
    n_cmp++; if (ans_vpn_o !== 27'h102) begin n_mis++; $display("[TB] FAIL ans_id2: got vpn=%h want 102", ans_vpn_o); end
    step();
    ptw_ans_valid_i = 1'b0; #1;
    n_cmp++; if (ans_vpn_o !== 27'h103 || empty_o !== 1'b1) begin n_mis++; $display("[TB] FAIL drain: got vpn=%h empty=%b want 103/1", ans_vpn_o, empty_o); end
  endtask

  task automatic test_merge();
    do_reset();
    ptw_req_ready_i = 1'b1;
    req_valid_i = 1'b1; req_vpn_i = 27'h200; req_dest_i = ITLB;
    step();
    req_valid_i = 1'b0;
    step();
    req_valid_i = 1'b1; req_vpn_i = 27'h200; req_dest_i = DTLB;
    #1;
    n_cmp++; if (req_ready_o !== 1'b1) begin n_mis++; $display("[TB] FAIL dup_req_ready: got %b want 1", req_ready_o); end
    step();
    req_valid_i = 1'b0; #1;
`ifdef L2_TLB_MSHR_MERGE_EN
    n_cmp++; if (ptw_req_valid_o !== 1'b0) begin n_mis++; $display("[TB] FAIL merge_no_walk: got %b want 0", ptw_req_valid_o); end
`else
    n_cmp++; if (ptw_req_valid_o !== 1'b1 || ptw_req_id_o !== 2'd1 || ptw_req_vpn_o !== 27'h200) begin
      n_mis++; $display("[TB] FAIL dup_walk: got v=%b id=%0d vpn=%h want 1/1/200", ptw_req_valid_o, ptw_req_id_o, ptw_req_vpn_o); end
`endif
    step();
    ptw_ans_valid_i = 1'b1; ptw_ans_id_i = 2'd0;
    step();
    ptw_ans_valid_i = 1'b0; #1;
`ifdef L2_TLB_MSHR_MERGE_EN
    n_cmp++; if (ans_valid_o !== 1'b1 || ans_vpn_o !== 27'h200 || ans_dest_mask_o !== 2'b11) begin
      n_mis++; $display("[TB] FAIL merge_mask: got v=%b vpn=%h m=%b want 1/200/11", ans_valid_o, ans_vpn_o, ans_dest_mask_o); end
`else
    n_cmp++; if (ans_valid_o !== 1'b1 || ans_vpn_o !== 27'h200 || ans_dest_mask_o !== 2'b01) begin
      n_mis++; $display("[TB] FAIL itlb_mask: got v=%b vpn=%h m=%b want 1/200/01", ans_valid_o, ans_vpn_o, ans_dest_mask_o); end
    ptw_ans_valid_i = 1'b1; ptw_ans_id_i = 2'd1;
    step();
    ptw_ans_valid_i = 1'b0; #1;
    n_cmp++; if (ans_valid_o !== 1'b1 || ans_dest_mask_o !== 2'b10) begin
      n_mis++; $display("[TB] FAIL dtlb_mask: got v=%b m=%b want 1/10", ans_valid_o, ans_dest_mask_o); end
`endif
    n_cmp++; if (empty_o !== 1'b1) begin n_mis++; $display("[TB] FAIL merge_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_flush();
    do_reset();
    ptw_req_ready_i = 1'b1;
    req_valid_i = 1'b1; req_vpn_i = 27'h300; req_dest_i = ITLB;
    step();
    req_vpn_i = 27'h301;
    step();
    req_valid_i = 1'b0; ptw_req_ready_i = 1'b0; flush_i = 1'b1;
    #1;
    n_cmp++; if (req_ready_o !== 1'b0) begin n_mis++; $display("[TB] FAIL flush_req_ready: got %b want 0", req_ready_o); end
    step();
    flush_i = 1'b0; ptw_req_ready_i = 1'b1; #1;
    n_cmp++; if (ptw_req_valid_o !== 1'b0 || empty_o !== 1'b0 || full_o !== 1'b0) begin
      n_mis++; $display("[TB] FAIL post_flush: got ptwv=%b empty=%b full=%b want 0/0/0", ptw_req_valid_o, empty_o, full_o); end
    step();
    ptw_ans_valid_i = 1'b1; ptw_ans_id_i = 2'd0;
    #1;
    n_cmp++; if (ptw_req_valid_o !== 1'b0) begin n_mis++; $display("[TB] FAIL queue_cleared: got %b want 0", ptw_req_valid_o); end
    step();
    ptw_ans_valid_i = 1'b0; #1;
    n_cmp++; if (ans_valid_o !== 1'b0 || empty_o !== 1'b1) begin
      n_mis++; $display("[TB] FAIL zombie_ans: got v=%b empty=%b want 0/1", ans_valid_o, empty_o); end
    req_valid_i = 1'b1; req_vpn_i = 27'h310;
    step();
    req_vpn_i = 27'h311; #1;
    n_cmp++; if (ptw_req_valid_o !== 1'b1 || ptw_req_id_o !== 2'd0 || ptw_req_vpn_o !== 27'h310) begin
      n_mis++; $display("[TB] FAIL reuse_issue0: got v=%b id=%0d vpn=%h want 1/0/310", ptw_req_valid_o, ptw_req_id_o, ptw_req_vpn_o); end
    step();
    req_valid_i = 1'b0; #1;
    n_cmp++; if (ptw_req_valid_o !== 1'b1 || ptw_req_id_o !== 2'd1 || ptw_req_vpn_o !== 27'h311) begin
      n_mis++; $display("[TB] FAIL reuse_issue1: got v=%b id=%0d vpn=%h want 1/1/311", ptw_req_valid_o, ptw_req_id_o, ptw_req_vpn_o); end
    step();
  endtask

  // 3N allocations under random PTW back-pressure and random answer order.
  task automatic test_wrap();
    vpn_t exp_q[$];
    int   out_id[$];
    vpn_t id_vpn[4];
    int   sent, issued, answered, max_out, cyc, k;
    bit   nxt_ans;
    vpn_t nxt_vpn;
    sent = 0; issued = 0; answered = 0; max_out = 0; cyc = 0;
    do_reset();
    while (answered < 12 && cyc < 400) begin
      nxt_ans = 1'b0; nxt_vpn = '0; ptw_ans_valid_i = 1'b0;
      if (out_id.size() > 0 && $urandom_range(0, 2) != 0) begin
        k = $urandom_range(0, out_id.size() - 1);
        ptw_ans_valid_i = 1'b1; ptw_ans_id_i = IDW'(out_id[k]);
        nxt_ans = 1'b1; nxt_vpn = id_vpn[out_id[k]];
        out_id.delete(k);
        answered++;
      end
      ptw_req_ready_i = 1'($urandom_range(0, 1));
      req_valid_i = (sent < 12);
      req_vpn_i = 27'h400 + 27'(sent);
      req_dest_i = (sent % 2 == 1) ? DTLB : ITLB;
      #1;
      if (req_valid_i && req_ready_o) begin exp_q.push_back(req_vpn_i); sent++; end
      if (ptw_req_valid_o && ptw_req_ready_i) begin
        n_cmp++;
        if (exp_q.size() == 0) begin n_mis++; $display("[TB] FAIL wrap_issue_%0d: got vpn=%h with no pending alloc", issued, ptw_req_vpn_o); end
        else if (ptw_req_vpn_o !== exp_q[0]) begin n_mis++; $display("[TB] FAIL wrap_issue_%0d: got vpn=%h want %h", issued, ptw_req_vpn_o, exp_q[0]); void'(exp_q.pop_front()); end
        else void'(exp_q.pop_front());
        id_vpn[ptw_req_id_o] = ptw_req_vpn_o;
        out_id.push_back(int'(ptw_req_id_o));
        issued++;
        if (out_id.size() > max_out) max_out = out_id.size();
      end
      step();
      n_cmp++;
      if (ans_valid_o !== nxt_ans || (nxt_ans && ans_vpn_o !== nxt_vpn)) begin
        n_mis++; $display("[TB] FAIL wrap_ans_c%0d: got v=%b vpn=%h want %b/%h", cyc, ans_valid_o, ans_vpn_o, nxt_ans, nxt_vpn); end
      cyc++;
    end
    idle_inputs();
    n_cmp++; if (cyc >= 400) begin n_mis++; $display("[TB] FAIL wrap_timeout: got %0d answered want 12", answered); end
    n_cmp++; if (issued !== 12) begin n_mis++; $display("[TB] FAIL wrap_issued: got %0d want 12", issued); end
    n_cmp++; if (max_out > MAXI) begin n_mis++; $display("[TB] FAIL wrap_max_inflight: got %0d want <= %0d", max_out, MAXI); end
    #1;
    n_cmp++; if (empty_o !== 1'b1) begin n_mis++; $display("[TB] FAIL wrap_empty: got %b want 1", empty_o); end
  endtask

  task automatic test_async_reset();
    do_reset();
    ptw_req_ready_i = 1'b1;
    req_valid_i = 1'b1; req_vpn_i = 27'h500;
    step();
    req_vpn_i = 27'h501;
    step();
    req_vpn_i = 27'h502;
    step();
    req_valid_i = 1'b0; ptw_ans_valid_i = 1'b1; ptw_ans_id_i = 2'd0;
    step();
    ptw_ans_valid_i = 1'b0; ptw_req_ready_i = 1'b0; #1;
    n_cmp++; if (ans_valid_o !== 1'b1 || empty_o !== 1'b0) begin
      n_mis++; $display("[TB] FAIL pre_reset_busy: got v=%b empty=%b want 1/0", ans_valid_o, empty_o); end
    @(negedge clk_i); #1;
    rst_ni = 1'b0; #1;
    n_cmp++; if (empty_o !== 1'b1 || full_o !== 1'b0 || req_ready_o !== 1'b1 || ptw_req_valid_o !== 1'b0) begin
      n_mis++; $display("[TB] FAIL async_reset_flags: got e=%b f=%b r=%b pv=%b want 1/0/1/0", empty_o, full_o, req_ready_o, ptw_req_valid_o); end
    n_cmp++; if (ans_valid_o !== 1'b0 || ans_vpn_o !== '0 || ans_dest_mask_o !== 2'b00) begin
      n_mis++; $display("[TB] FAIL async_reset_ans: got v=%b vpn=%h m=%b want 0/0/00", ans_valid_o, ans_vpn_o, ans_dest_mask_o); end
    #1 rst_ni = 1'b1;
    step();
  endtask

  initial begin
    $display("[TB] start");
    test_reset();
    test_fill();
    test_ooo_answer();
    test_merge();
    test_flush();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
